tx_fifo_arbiter: RTL and testbench
==================================

Name: tx_fifo_arbiter

Overview:
- Shares one UART transmitter holding buffer (tx_load/tx_buf_empty handshake) among four byte FIFOs, e.g. debug, telemetry and command-echo streams.
- Grants channels round-robin with a per-grant burst limit.
- Optionally emits a channel-select header byte whenever the transmitting channel changes.
- Replaces the single-FIFO TX feeder wherever more than one source drives the same UART.

Parameters:
- MAX_BURST, 16: max data bytes sent per grant; legal range 1..255.
- HDR_EN, 1: 1 = emit header byte on channel change; 0 = no headers.
- HDR_BASE, 8'hF0: header byte is HDR_BASE | channel; low 2 bits of HDR_BASE must be 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  4  per-channel FIFO empty flag; bit i = channel i.
- fifo_dout  in  32  packed FIFO data; channel i = bits [8i+7:8i]; valid the cycle after that channel's fifo_rd pulse has been sampled.
- ch_en  in  4  per-channel enable; a disabled channel is never granted.
- tx_buf_empty  in  1  UART holding buffer empty.
- fifo_rd  out  4  one-cycle read strobe, at most one bit set.
- tx_data  out  8  byte presented to UART; registered.
- tx_load  out  1  one-cycle load strobe to UART.
- busy  out  1  high in every state except IDLE.
- grant_ch  out  2  currently/last granted channel.

Behaviour:
- Reset (async, reset=0): fifo_rd=0, tx_load=0, tx_data=0, busy=0, grant_ch=0, rr_ptr=3, burst_cnt=0, last_valid=0, state=IDLE. Reset mid-transfer drops all strobes immediately; any byte already read from a FIFO is lost.
- req = ~fifo_empty & ch_en.
- Round-robin search order: rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4). After reset the first grant goes to the lowest requesting channel from ch0.
- IDLE:
  - If req!=0 and tx_buf_empty=1: grant_ch<=pick; burst_cnt<=0.
  - Then go to HDR if HDR_EN and (!last_valid or pick!=last_ch); otherwise go to RD.
  - Else stay in IDLE.
- HDR: tx_data<=HDR_BASE|grant_ch; tx_load<=1; last_ch<=grant_ch; last_valid<=1; from_hdr<=1 -> GAP.
- RD: fifo_rd[grant_ch]<=1; from_hdr<=0 -> RDW.
- RDW: fifo_rd<=0 -> CAP. Strobe width is exactly one cycle.
- CAP: tx_data<=fifo_dout[grant_ch]; tx_load<=1; burst_cnt<=burst_cnt+1 -> GAP.
- GAP: tx_load<=0 -> WAIT. The one-cycle gap lets the UART deassert tx_buf_empty.
- WAIT: hold until tx_buf_empty=1, then:
  - from_hdr: -> RD. The FIFO is known non-empty from the grant decision.
  - Else if burst_cnt<MAX_BURST and req[grant_ch]: -> RD. Burst continues.
  - Else: rr_ptr<=grant_ch -> IDLE.
- Latency: grant to first tx_load is 4 cycles without a header (IDLE->RD->RDW->CAP, tx_load high in GAP cycle). With a header, tx_load rises 2 cycles after grant.
- Byte-to-byte spacing inside a burst: 4 cycles after tx_buf_empty returns high.
- fifo_empty of the granted channel rising mid-burst: burst ends at the next WAIT exit; no read of an empty FIFO is issued.
- ch_en bit cleared mid-burst: the in-flight byte completes; no further reads from that channel.
- Two or more simultaneous requesters: strict rotation. No channel gets a second grant while another requesting, enabled channel is waiting.
- tx_data holds its value between loads. tx_load and fifo_rd are never high in the same cycle.
- Data bytes are not escaped. Sources must not emit HDR_BASE..HDR_BASE+3 when HDR_EN=1; framing beyond that is out of scope.

Test Plan:
- Reset, then ch0 FIFO holds 3 bytes {11,22,33}, others empty, HDR_EN=1 -> UART receives F0,11,22,33; exactly 3 fifo_rd[0] pulses; busy falls after last WAIT.
- ch1 and ch2 each hold 20 bytes, MAX_BURST=16 -> sequence F1,16×ch1, F2,16×ch2, F1,4×ch1, F2,4×ch2.
- ch3 sends 2 bytes, later ch3 sends 2 more with no intervening channel -> header F3 appears only once.
- Hold tx_buf_empty low 50 cycles after a load -> no fifo_rd or tx_load during stall; resumes 4 cycles after tx_buf_empty=1.
- Assert reset mid-burst during RDW -> fifo_rd and tx_load 0 same cycle; after release the next transfer re-emits the header.
- ch_en=4'b1101 with all FIFOs non-empty -> ch1 never granted; rotation 0,2,3,0...

Source files
------------

// File: rtl/tx_fifo_arbiter_if.sv
// tx_fifo_arbiter_if: FIFO-side and UART-side signals shared by the arbiter and its environment
//   fifo_empty[3:0]  per-channel FIFO empty flags
//   fifo_dout[31:0]  packed FIFO read data, channel i in bits [8i+7:8i]
//   ch_en[3:0]       per-channel grant enable
//   tx_buf_empty     UART holding buffer empty
//   fifo_rd[3:0]     one-cycle FIFO read strobes
//   tx_data[7:0]     byte presented to the UART
//   tx_load          one-cycle UART load strobe
//   busy             arbiter not idle
//   grant_ch[1:0]    current or last granted channel
// master = arbiter side, slave = FIFO/UART environment side.
interface tx_fifo_arbiter_if;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_dout;
  logic [3:0]  ch_en;
  logic        tx_buf_empty;
  logic [3:0]  fifo_rd;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        busy;
  logic [1:0]  grant_ch;
  modport master (
    input  fifo_empty, fifo_dout, ch_en, tx_buf_empty,
    output fifo_rd, tx_data, tx_load, busy, grant_ch
  );
  modport slave (
    output fifo_empty, fifo_dout, ch_en, tx_buf_empty,
    input  fifo_rd, tx_data, tx_load, busy, grant_ch
  );
endinterface

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: round-robin feeder of four byte FIFOs into one UART holding buffer
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    tx_fifo_arbiter_if.master (FIFO flags/data/strobes, UART handshake, status)
// Each grant sends up to MAX_BURST bytes; with HDR_EN a header byte HDR_BASE|ch
// precedes the first burst after a change of transmitting channel.
module tx_fifo_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [7:0]  HDR_BASE  = 8'hF0
) (
  input logic               clk,
  input logic               reset,
  tx_fifo_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, RD, RDW, CAP, GAP, WAIT} state_t;
  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d, grant_ch_q, grant_ch_d, last_ch_q, last_ch_d, pick;
  logic       last_valid_q, last_valid_d, from_hdr_q, from_hdr_d, tx_load_q, tx_load_d;
  logic [7:0] burst_cnt_q, burst_cnt_d, tx_data_q, tx_data_d, lane;
  logic [3:0] fifo_rd_q, fifo_rd_d, req;
  assign req  = ~bus.fifo_empty & bus.ch_en;
  assign lane = bus.fifo_dout[8*grant_ch_q +: 8];
  // Scan farthest-first so the nearest requester after rr_ptr overrides.
  always_comb begin
    pick = rr_ptr_q;
    for (int k = 4; k >= 1; k--)
      if (req[rr_ptr_q + 2'(k)]) pick = rr_ptr_q + 2'(k);
  end
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_ch_d   = grant_ch_q;
    last_ch_d    = last_ch_q;
    last_valid_d = last_valid_q;
    from_hdr_d   = from_hdr_q;
    burst_cnt_d  = burst_cnt_q;
    tx_data_d    = tx_data_q;
    tx_load_d    = 1'b0;
    fifo_rd_d    = '0;
    case (state_q)
      IDLE: if (|req && bus.tx_buf_empty) begin
        grant_ch_d  = pick;
        burst_cnt_d = '0;
        state_d     = (HDR_EN && (!last_valid_q || pick != last_ch_q)) ? HDR : RD;
      end
      HDR: begin
        tx_data_d    = HDR_BASE | {6'd0, grant_ch_q};
        tx_load_d    = 1'b1;
        last_ch_d    = grant_ch_q;
        last_valid_d = 1'b1;
        from_hdr_d   = 1'b1;
        state_d      = GAP;
      end
      RD: begin
        fifo_rd_d  = 4'b0001 << grant_ch_q;
        from_hdr_d = 1'b0;
        state_d    = RDW;
      end
      RDW: state_d = CAP;
      CAP: begin
        tx_data_d   = lane;
        tx_load_d   = 1'b1;
        burst_cnt_d = burst_cnt_q + 8'd1;
        state_d     = GAP;
      end
      GAP: state_d = WAIT;
      WAIT: if (bus.tx_buf_empty) begin
        // After a header the granted FIFO is known non-empty from the grant decision.
        if (from_hdr_q || (burst_cnt_q < 8'(MAX_BURST) && req[grant_ch_q])) state_d = RD;
        else begin
          rr_ptr_d = grant_ch_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd3;
      grant_ch_q   <= 2'd0;
      last_ch_q    <= 2'd0;
      last_valid_q <= 1'b0;
      from_hdr_q   <= 1'b0;
      burst_cnt_q  <= '0;
      tx_data_q    <= '0;
      tx_load_q    <= 1'b0;
      fifo_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_ch_q   <= grant_ch_d;
      last_ch_q    <= last_ch_d;
      last_valid_q <= last_valid_d;
      from_hdr_q   <= from_hdr_d;
      burst_cnt_q  <= burst_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_load_q    <= tx_load_d;
      fifo_rd_q    <= fifo_rd_d;
    end
  assign bus.fifo_rd  = fifo_rd_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.busy     = state_q != IDLE;
  assign bus.grant_ch = grant_ch_q;
endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: scoreboard bench with FIFO/UART models and a queue-level arbitration model
module tb_tx_fifo_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  tx_fifo_arbiter_if bus();
  tx_fifo_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] fq[4][$];
  logic [7:0] mq[4][$];
  logic [7:0] exp_b[$];
  bit         exp_lat[$];
  logic [7:0] pv[4];
  bit         pend[4];
  int         rd_cnt[4];
  int         stall = 0, since = 0, m_rr = 3, m_last = -1;
  bit         long_stall = 1'b0;
  logic [7:0] e_b;
  bit         e_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: with all data queued up front, serve channels in rotation after the
  // last granted one, up to 16 bytes each, header when the channel differs from the
  // last header's channel.
  task automatic model_run(input logic [3:0] en);
    int ch;
    bit first;
    forever begin
      ch = -1;
      for (int k = 1; k <= 4; k++)
        if (ch < 0 && en[(m_rr + k) % 4] && mq[(m_rr + k) % 4].size() > 0) ch = (m_rr + k) % 4;
      if (ch < 0) break;
      first = 1'b1;
      if (ch != m_last) begin
        exp_b.push_back(8'hF0 | 8'(ch));
        exp_lat.push_back(1'b0);
        m_last = ch;
        first = 1'b0;
      end
      for (int n = 0; n < 16 && mq[ch].size() > 0; n++) begin
        exp_b.push_back(mq[ch].pop_front());
        exp_lat.push_back(!first);
        first = 1'b0;
      end
      m_rr = ch;
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    fq[ch].push_back(b);
    mq[ch].push_back(b);
  endtask

  task automatic load_rand(input int ch, input int n);
    logic [7:0] b;
    repeat (n) begin
      b = 8'($urandom_range(0, 255));
      if ((b & 8'hFC) == 8'hF0) b = b ^ 8'h0F;
      push(ch, b);
    end
  endtask

  task automatic start(input logic [3:0] en);
    bus.ch_en = en;
    model_run(en);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_b.size() != 0 || bus.busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"}, 32'(t < 5000), 1);
    repeat (3) @(negedge clk);
    chk({name, "_idle"}, {bus.busy, 8'(exp_b.size())}, 0);
    exp_b.delete();
    exp_lat.delete();
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      mq[i].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // FIFO model, UART model and output monitor, all sampled on the falling edge.
  always @(negedge clk) if (reset) begin
    since++;
    for (int i = 0; i < 4; i++)
      if (pend[i]) begin
        bus.fifo_dout[8*i +: 8] = pv[i];
        pend[i] = 1'b0;
      end
    for (int i = 0; i < 4; i++)
      if (bus.fifo_rd[i]) begin
        chk("rd_legal", {bus.ch_en[i], fq[i].size() != 0, bus.grant_ch == 2'(i), bus.tx_load}, 4'b1110);
        if (fq[i].size() != 0) pv[i] = fq[i].pop_front();
        pend[i] = 1'b1;
        rd_cnt[i]++;
      end
    if (!bus.tx_buf_empty) begin
      chk("stall_quiet", {bus.tx_load, bus.fifo_rd}, 0);
      stall--;
      if (stall <= 0) begin
        bus.tx_buf_empty = 1'b1;
        since = 0;
      end
    end
    if (bus.tx_load) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got %0h want none", bus.tx_data);
      end else begin
        e_b = exp_b.pop_front();
        e_l = exp_lat.pop_front();
        chk("tx_data", bus.tx_data, e_b);
        if (e_l) chk("resume_latency", since, 4);
      end
      bus.tx_buf_empty = 1'b0;
      stall = long_stall ? 50 : int'($urandom_range(1, 6));
      long_stall = 1'b0;
    end
    for (int i = 0; i < 4; i++) bus.fifo_empty[i] = fq[i].size() == 0;
  end

  initial begin
    int t;
    bus.fifo_empty = '1;
    bus.fifo_dout = '0;
    bus.ch_en = '0;
    bus.tx_buf_empty = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.fifo_rd, bus.tx_load, bus.tx_data, bus.busy, bus.grant_ch}, 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    @(posedge clk); #2
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    rd_cnt[0] = 0;
    start(4'hF);
    drain("ch0_three");
    chk("ch0_rd_pulses", rd_cnt[0], 3);

    @(posedge clk); #2
    load_rand(1, 20); load_rand(2, 20);
    start(4'hF);
    drain("burst_split");

    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #2
      load_rand(3, 2);
      start(4'hF);
      drain("ch3_repeat");
    end

    @(posedge clk); #2
    long_stall = 1'b1;
    load_rand(0, 3);
    start(4'hF);
    drain("long_stall");

    @(posedge clk); #2
    for (int i = 0; i < 4; i++) load_rand(i, 5);
    start(4'b1101);
    drain("ch1_disabled");

    @(posedge clk); #2
    load_rand(2, 6);
    start(4'hF);
    t = 0;
    while (!(exp_b.size() <= 5 && bus.fifo_rd != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reach_rdw", 32'(t < 500), 1);
    #1 reset = 1'b0;
    #1 chk("reset_mid", {bus.fifo_rd, bus.tx_load, bus.busy, bus.grant_ch, bus.tx_data}, 0);
    exp_b.delete();
    exp_lat.delete();
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      mq[i].delete();
      pend[i] = 1'b0;
    end
    bus.fifo_empty = '1;
    bus.tx_buf_empty = 1'b1;
    stall = 0;
    m_rr = 3;
    m_last = -1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2
    load_rand(2, 3);
    start(4'hF);
    drain("after_reset");

    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #2
      long_stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) load_rand(i, int'($urandom_range(0, 20)));
      start(4'($urandom_range(1, 15)));
      drain("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
